// File: rtl/fifo_wr_sched_pkg.sv
// Shared widths and helpers for the fifomem write scheduler and the fifomem itself,
// so both sides of the memory interface agree on data and address sizes.
package fifo_wr_sched_pkg;

   localparam int FIFO_DATASIZE = 8;
   localparam int FIFO_ADDRSIZE = 4;
   localparam int FIFO_NREQ     = 4;
   localparam int FIFO_AFULL_TH = 12;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_wr_sched_if.sv
// Bundle of producer, consumer and fifomem-facing signals of the write scheduler.
// The scheduler uses the slave view; producers/consumer/memory use the master view.
interface fifo_wr_sched_if
   import fifo_wr_sched_pkg::*;
#(
   parameter int DATASIZE = FIFO_DATASIZE,
   parameter int ADDRSIZE = FIFO_ADDRSIZE,
   parameter int NREQ     = FIFO_NREQ
) ();

   logic [NREQ-1:0]          req;
   logic [NREQ*DATASIZE-1:0] req_data;
   logic [NREQ-1:0]          gnt;
   logic [DATASIZE-1:0]      mem_wdata;
   logic [ADDRSIZE-1:0]      mem_waddr;
   logic                     mem_wclken;
   logic                     mem_wfull;
   logic [ADDRSIZE-1:0]      mem_raddr;
   logic                     rd_en;
   logic                     empty;
   logic                     full;
   logic                     almost_full;
   logic [ADDRSIZE:0]        count;

   modport slave (
      input  req, req_data, rd_en,
      output gnt, mem_wdata, mem_waddr, mem_wclken, mem_wfull, mem_raddr,
             empty, full, almost_full, count
   );

   modport master (
      output req, req_data, rd_en,
      input  gnt, mem_wdata, mem_waddr, mem_wclken, mem_wfull, mem_raddr,
             empty, full, almost_full, count
   );

endinterface

// File: rtl/fifo_wr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i,
// wrapping modulo NREQ. The owner of ptr_i advances it after each grant.
module fifo_wr_sched_rr_arbiter
   import fifo_wr_sched_pkg::*;
#(
   parameter int NREQ = FIFO_NREQ,
   parameter int IDXW = clog2(FIFO_NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDXW-1:0] ptr_i,
   input  logic            en_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDXW-1:0] gntIdx_o
);

   logic [IDXW:0]   sum;
   logic [IDXW-1:0] idx;
   logic            found;

   // ptr_i < NREQ and k < NREQ, so one conditional subtract gives the modulo
   always_comb begin
      gnt_o    = '0;
      gntIdx_o = '0;
      found    = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr_i} + (IDXW+1)'(k);
         if (sum >= (IDXW+1)'(NREQ)) begin
            sum = sum - (IDXW+1)'(NREQ);
         end
         idx = sum[IDXW-1:0];
         if (!found && en_i && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gntIdx_o   = idx;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_sched.sv
// Single-clock fifomem controller: round-robin sharing of the write port among NREQ
// producers, plus read/write pointers, occupancy count and status flags for one consumer.
module fifo_wr_sched
   import fifo_wr_sched_pkg::*;
#(
   parameter int DATASIZE = FIFO_DATASIZE,
   parameter int ADDRSIZE = FIFO_ADDRSIZE,
   parameter int NREQ     = FIFO_NREQ,
   parameter int AFULL_TH = FIFO_AFULL_TH
) (
   input logic             wclk,
   input logic             wrst,
   fifo_wr_sched_if.slave  bus
);

   localparam int IDXW = clog2(NREQ);
   localparam int PTRW = ADDRSIZE + 1;

   logic [NREQ-1:0]     gnt;
   logic [IDXW-1:0]     gntIdx;
   logic                arbEn;
   logic                push;
   logic                pop;
   logic [DATASIZE-1:0] wdata;

   logic [PTRW-1:0] wrPtr_q, wrPtr_d;
   logic [PTRW-1:0] rdPtr_q, rdPtr_d;
   logic [PTRW-1:0] count_q, count_d;
   logic [IDXW-1:0] rrPtr_q, rrPtr_d;
   logic            empty_q, empty_d;
   logic            full_q, full_d;
   logic            almostFull_q, almostFull_d;

   // A full FIFO blocks every grant, even when the consumer pops in the same cycle
   assign arbEn = !wrst && !full_q;

   fifo_wr_sched_rr_arbiter #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) uArbiter (
      .req_i    (bus.req),
      .ptr_i    (rrPtr_q),
      .en_i     (arbEn),
      .gnt_o    (gnt),
      .gntIdx_o (gntIdx)
   );

   always_comb begin
      wdata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            wdata = bus.req_data[i*DATASIZE +: DATASIZE];
         end
      end
   end

   // Flags come from the next pointers, so they are valid the cycle after the update
   always_comb begin
      push         = |gnt;
      pop          = bus.rd_en && !empty_q;
      wrPtr_d      = wrPtr_q + PTRW'(push);
      rdPtr_d      = rdPtr_q + PTRW'(pop);
      count_d      = wrPtr_d - rdPtr_d;
      empty_d      = (wrPtr_d == rdPtr_d);
      full_d       = (wrPtr_d[ADDRSIZE] != rdPtr_d[ADDRSIZE]) &&
                     (wrPtr_d[ADDRSIZE-1:0] == rdPtr_d[ADDRSIZE-1:0]);
      almostFull_d = (count_d >= PTRW'(AFULL_TH));
      rrPtr_d      = rrPtr_q;
      if (push) begin
         rrPtr_d = (gntIdx == IDXW'(NREQ-1)) ? '0 : gntIdx + IDXW'(1);
      end
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         wrPtr_q      <= '0;
         rdPtr_q      <= '0;
         count_q      <= '0;
         rrPtr_q      <= '0;
         empty_q      <= 1'b1;
         full_q       <= 1'b0;
         almostFull_q <= 1'b0;
      end else begin
         wrPtr_q      <= wrPtr_d;
         rdPtr_q      <= rdPtr_d;
         count_q      <= count_d;
         rrPtr_q      <= rrPtr_d;
         empty_q      <= empty_d;
         full_q       <= full_d;
         almostFull_q <= almostFull_d;
      end
   end

   assign bus.gnt         = gnt;
   assign bus.mem_wdata   = wdata;
   assign bus.mem_wclken  = push;
   assign bus.mem_wfull   = full_q;
   assign bus.mem_waddr   = wrPtr_q[ADDRSIZE-1:0];
   assign bus.mem_raddr   = rdPtr_q[ADDRSIZE-1:0];
   assign bus.empty       = empty_q;
   assign bus.full        = full_q;
   assign bus.almost_full = almostFull_q;
   assign bus.count       = count_q;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed bench for fifo_wr_sched with a behavioural fifomem, a reference arbiter/FIFO
// model and a data scoreboard that checks read order against grant order.
module tb_fifo_wr_sched;
   import fifo_wr_sched_pkg::*;

   logic wclk = 1'b0;
   logic wrst;

   fifo_wr_sched_if #(.DATASIZE(8), .ADDRSIZE(4), .NREQ(4)) bus ();

   fifo_wr_sched #(
      .DATASIZE (8),
      .ADDRSIZE (4),
      .NREQ     (4),
      .AFULL_TH (12)
   ) dut (
      .wclk (wclk),
      .wrst (wrst),
      .bus  (bus)
   );

   always #5 wclk = ~wclk;

   // Behavioural fifomem: registered write, combinational read
   logic [7:0] memArr [16];
   logic [7:0] rdata;
   always @(posedge wclk) begin
      if (bus.mem_wclken && !bus.mem_wfull) begin
         memArr[bus.mem_waddr] <= bus.mem_wdata;
      end
   end
   assign rdata = memArr[bus.mem_raddr];

   int tests = 0;
   int fails = 0;

   int mPtr, mCount, mW, mR;
   int seq [4];
   logic [7:0] word [4];
   logic [7:0] sbQ [$];
   logic [3:0] sampledGnt;
   int lastGi;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive, check combinational outputs, clock, update model, check state
   task automatic applyStimulus(input logic rstIn, input logic [3:0] reqIn, input logic rdIn);
      logic [3:0] eg;
      int gi;
      int idx;
      logic doPop;
      wrst       = rstIn;
      bus.req    = reqIn;
      bus.rd_en  = rdIn;
      for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = word[i];
      #1;
      eg = '0;
      gi = -1;
      if (!rstIn && mCount != 16) begin
         for (int k = 0; k < 4; k++) begin
            idx = (mPtr + k) % 4;
            if (gi < 0 && reqIn[idx]) begin
               gi = idx;
               eg[idx] = 1'b1;
            end
         end
      end
      sampledGnt = bus.gnt;
      lastGi     = gi;
      checkOutput("gnt", bus.gnt, eg);
      checkOutput("wclken", bus.mem_wclken, |eg);
      if (gi >= 0) begin
         checkOutput("waddr", bus.mem_waddr, 32'(mW % 16));
         checkOutput("wdata", bus.mem_wdata, word[gi]);
      end
      doPop = !rstIn && rdIn && (mCount > 0);
      if (doPop) begin
         checkOutput("raddr", bus.mem_raddr, 32'(mR % 16));
         checkOutput("rdata", rdata, sbQ[0]);
      end
      @(posedge wclk);
      #1;
      if (rstIn) begin
         mPtr = 0; mCount = 0; mW = 0; mR = 0;
         sbQ.delete();
      end else begin
         if (gi >= 0) begin
            sbQ.push_back(word[gi]);
            mW = (mW + 1) % 32;
            mPtr = (gi + 1) % 4;
            mCount++;
            seq[gi]++;
            word[gi] = 8'(gi * 64 + (seq[gi] % 64));
         end
         if (doPop) begin
            void'(sbQ.pop_front());
            mR = (mR + 1) % 32;
            mCount--;
         end
      end
      checkOutput("count", bus.count, 32'(mCount));
      checkOutput("empty", bus.empty, mCount == 0);
      checkOutput("full", bus.full, mCount == 16);
      checkOutput("almost_full", bus.almost_full, mCount >= 12);
      checkOutput("wfull", bus.mem_wfull, mCount == 16);
   endtask

   initial begin
      logic [3:0] reqState;
      int grants;
      int raddrHold;
      for (int i = 0; i < 4; i++) begin
         seq[i]  = 0;
         word[i] = 8'(i * 64);
      end
      mPtr = 0; mCount = 0; mW = 0; mR = 0; lastGi = -1;
      wrst = 1'b1; bus.req = '0; bus.req_data = '0; bus.rd_en = 1'b0;

      applyStimulus(1'b1, 4'b0000, 1'b0);
      applyStimulus(1'b1, 4'b0000, 1'b0);
      checkOutput("reset_empty", bus.empty, 1);
      checkOutput("reset_count", bus.count, 0);

      // Round-robin with all producers requesting
      for (int k = 0; k < 8; k++) begin
         applyStimulus(1'b0, 4'b1111, 1'b0);
         checkOutput("rr_gnt", sampledGnt, 4'b0001 << (k % 4));
      end
      checkOutput("rr_count8", bus.count, 8);

      // Reset mid-traffic: pointer was moved to producer 1 first
      applyStimulus(1'b0, 4'b1111, 1'b0);
      applyStimulus(1'b1, 4'b1111, 1'b1);
      checkOutput("rst_gnt0", sampledGnt, 4'b0000);
      applyStimulus(1'b1, 4'b1111, 1'b0);
      checkOutput("rst_gnt1", sampledGnt, 4'b0000);
      checkOutput("rst_empty", bus.empty, 1);
      checkOutput("rst_full", bus.full, 0);
      checkOutput("rst_count", bus.count, 0);
      applyStimulus(1'b0, 4'b1111, 1'b0);
      checkOutput("post_rst_gnt", sampledGnt, 4'b0001);

      // Fill from a single producer
      applyStimulus(1'b1, 4'b0000, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         applyStimulus(1'b0, 4'b0001, 1'b0);
         if (k == 11) checkOutput("fill_af11", bus.almost_full, 0);
         if (k == 12) checkOutput("fill_af12", bus.almost_full, 1);
      end
      checkOutput("fill_full", bus.full, 1);
      applyStimulus(1'b0, 4'b0001, 1'b0);
      checkOutput("fill_gnt17", sampledGnt, 4'b0000);

      // Full with simultaneous pop and request
      applyStimulus(1'b0, 4'b0001, 1'b1);
      checkOutput("fullpop_gnt", sampledGnt, 4'b0000);
      checkOutput("fullpop_count", bus.count, 15);
      checkOutput("fullpop_full", bus.full, 0);
      applyStimulus(1'b0, 4'b0001, 1'b0);
      checkOutput("refill_gnt", sampledGnt, 4'b0001);
      checkOutput("refill_count", bus.count, 16);

      // Drain, then pop while empty
      for (int k = 0; k < 16; k++) applyStimulus(1'b0, 4'b0000, 1'b1);
      checkOutput("drain_empty", bus.empty, 1);
      raddrHold = mR % 16;
      applyStimulus(1'b0, 4'b0000, 1'b1);
      checkOutput("empty_pop_raddr", bus.mem_raddr, 32'(raddrHold));
      checkOutput("empty_pop_count", bus.count, 0);
      for (int k = 0; k < 5; k++) applyStimulus(1'b0, 4'b0100, 1'b0);
      applyStimulus(1'b0, 4'b0010, 1'b1);
      checkOutput("pushpop_count", bus.count, 5);

      // Wrap: 40 grants with held requests and random reads
      reqState = '0;
      grants   = 0;
      for (int it = 0; it < 400 && grants < 40; it++) begin
         reqState = reqState | 4'($urandom_range(0, 15));
         applyStimulus(1'b0, reqState, 1'($urandom_range(0, 1)));
         if (lastGi >= 0) begin
            reqState[lastGi] = 1'b0;
            grants++;
         end
      end
      for (int k = 0; k < 20; k++) applyStimulus(1'b0, 4'b0000, 1'b1);
      checkOutput("wrap_empty", bus.empty, 1);
      checkOutput("wrap_count", bus.count, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
